// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl -- bit-serial ALU with valid/ready handshakes.
//
// Operands are latched on the accepting edge and processed LSB first, one bit
// per clock, through a single 1-bit slice.  The slice carry is registered and
// fed back as the carry-in of the next bit.  A result takes exactly WIDTH
// cycles from the accept edge to out_valid, and is then held until the
// consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   in_valid   request valid
//   in_ready   block idle, can accept a request
//   a, b       operands (WIDTH bits)
//   operation  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT/SUB, others sum path
//   out_valid  result/flags valid
//   out_ready  consumer accepts result
//   result     computed value
//   carry_out  carry out of MSB (sum path only)
//   overflow   signed overflow (sum path only)
//   zero       result == 0
//
// Build option:
//   ALU_SERIAL_SLT_EN  when defined, op 111 rewrites the result to the
//                      set-less-than bit; otherwise op 111 is a plain SUB.

module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             carry;

    // FSM control strobes
    logic load, step, last;

    // Slice signals
    logic ai, bi, binv, bmux, s_and, s_or, s_sum, c_next, bit_res;
    logic logic_op;
    logic [WIDTH-1:0] res_step;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last = (cnt == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // 1-bit slice
    // ------------------------------------------------------------------
    always_comb begin
        ai       = a_r[cnt];
        bi       = b_r[cnt];
        binv     = op_r[2];
        bmux     = binv ? ~bi : bi;
        s_and    = ai & bi;           // logic ops use un-inverted b
        s_or     = ai | bi;
        s_sum    = ai ^ bmux ^ carry;
        c_next   = (ai & bmux) | ((ai ^ bmux) & carry);
        logic_op = (op_r[2:1] == 2'b00);
        if (op_r == 3'b000)      bit_res = s_and;
        else if (op_r == 3'b001) bit_res = s_or;
        else                     bit_res = s_sum;
        res_step      = result;
        res_step[cnt] = bit_res;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= 3'b000;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            a_r       <= a;
            b_r       <= b;
            op_r      <= operation;
            cnt       <= '0;
            // carry-in of 1 completes the two's complement for subtraction
            carry     <= operation[2];
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (step) begin
            cnt    <= cnt + CW'(1);
            carry  <= c_next;
            result <= res_step;
            if (last) begin
                // at the MSB, 'carry' is the carry into the MSB
                carry_out <= logic_op ? 1'b0 : c_next;
                overflow  <= logic_op ? 1'b0 : (carry ^ c_next);
`ifdef ALU_SERIAL_SLT_EN
                // signed less-than = sign of difference corrected by overflow
                if (op_r == 3'b111)
                    result <= {{(WIDTH-1){1'b0}}, s_sum ^ carry ^ c_next};
`endif
            end
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out, overflow, zero;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .operation(operation),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every result handoff
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !prev_ov)
                check("latency", 64'(cyc - acc_cyc), 64'(W));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, ".result"},    64'(result),    64'(e.res));
                    check({e.name, ".carry_out"}, 64'(carry_out), 64'(e.c));
                    check({e.name, ".overflow"},  64'(overflow),  64'(e.v));
                    check({e.name, ".zero"},      64'(zero),      64'(e.z));
                end
            end
        end
        prev_ov = reset ? 1'b0 : out_valid;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(0), 64'(1));
    endtask

    // Issue one request; push its expected response unless aborted later
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] top,
                         input logic push, input logic [W-1:0] er, input logic ec,
                         input logic ev, input logic ez, input string nm);
        exp_t e;
        wait_idle();
        a = ta; b = tb_; operation = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
        // inputs must be ignored after the accept edge
        a = W'($urandom); b = W'($urandom); operation = 3'($urandom);
        if (push) begin
            e.res = er; e.c = ec; e.v = ev; e.z = ez; e.name = nm;
            sb.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; operation = 3'b000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst.in_ready",  64'(in_ready),  64'(1));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.zero",      64'(zero),      64'(1));
        check("rst.result",    64'(result),    64'(0));

        do_op(8'h7F, 8'h01, 3'b010, 1, 8'h80, 0, 1, 0, "add_ovf");
        do_op(8'h05, 8'h05, 3'b110, 1, 8'h00, 1, 0, 1, "sub_eq");
        do_op(8'hF0, 8'h3C, 3'b000, 1, 8'h30, 0, 0, 0, "and");
        do_op(8'hF0, 8'h3C, 3'b001, 1, 8'hFC, 0, 0, 0, "or");
`ifdef ALU_SERIAL_SLT_EN
        do_op(8'h80, 8'h01, 3'b111, 1, 8'h01, 1, 1, 0, "slt");
        do_op(8'h05, 8'h03, 3'b111, 1, 8'h00, 1, 0, 1, "slt_false");
`else
        do_op(8'h80, 8'h01, 3'b111, 1, 8'h7F, 1, 1, 0, "slt_as_sub");
        do_op(8'h05, 8'h03, 3'b111, 1, 8'h02, 1, 0, 0, "slt_as_sub2");
`endif
        do_op(8'hFF, 8'h01, 3'b010, 1, 8'h00, 1, 0, 1, "add_wrap");
        do_op(8'h03, 8'h05, 3'b110, 1, 8'hFE, 0, 0, 0, "sub_neg");
        do_op(8'h10, 8'h20, 3'b011, 1, 8'h30, 0, 0, 0, "op011_sum");
        do_op(8'h10, 8'h20, 3'b100, 1, 8'hF0, 0, 0, 0, "op100_sub");
        do_op(8'h80, 8'h80, 3'b010, 1, 8'h00, 1, 1, 1, "add_negovf");

        // Back-pressure: hold the result for 5 cycles
        wait_idle();
        out_ready = 1'b0;
        do_op(8'h7F, 8'h01, 3'b010, 1, 8'h80, 0, 1, 0, "bp");
        repeat (W) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", 64'(out_valid), 64'(1));
            check("bp.in_ready",  64'(in_ready),  64'(0));
            check("bp.result",    64'(result),    64'(8'h80));
            check("bp.overflow",  64'(overflow),  64'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.idle_after", 64'(in_ready), 64'(1));

        // Reset while bit 3 is being processed: aborted, no result
        do_op(8'h55, 8'h22, 3'b010, 0, 8'h00, 0, 0, 0, "aborted");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort.in_ready",  64'(in_ready),  64'(1));
        check("abort.out_valid", 64'(out_valid), 64'(0));
        check("abort.result",    64'(result),    64'(0));
        check("abort.zero",      64'(zero),      64'(1));
        do_op(8'h03, 8'h04, 3'b010, 1, 8'h07, 0, 0, 0, "add_after_rst");

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
            if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/op request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 operation  input  3  op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others use the sum path.
REQ-009 out_valid  output  1  result registers valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  computed value.
REQ-012 carry_out  output  1  carry out of MSB on the sum path; 0 for AND/OR.
REQ-013 overflow  output  1  signed overflow on the sum path; 0 for AND/OR.
REQ-014 zero  output  1  high when result equals 0.

Function
REQ-015 The block SHALL compute bit-serially, LSB first, one bit per clock, through a single 1-bit slice whose carry-out is registered and fed back as the next bit's carry-in.
REQ-016 FSM states: IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 IDLE: on in_valid&&in_ready, latch a, b and operation; clear the bit counter; load carry with operation[2]; go to RUN.
REQ-018 Slice: Binvert = operation[2]; bmux = Binvert ? ~b[i] : b[i]; AND = a[i]&b[i]; OR = a[i]|b[i]; AND and OR use un-inverted b.
REQ-019 Slice: sum = a[i]^bmux^carry; next carry = (a[i]&bmux)|((a[i]^bmux)&carry).
REQ-020 Slice result select: op 000 selects AND, op 001 selects OR, every other op selects sum.
REQ-021 RUN: each cycle write the slice result into result bit i and increment i; the cycle processing bit WIDTH-1 transitions to DONE.
REQ-022 Latency SHALL be exactly WIDTH cycles from the accepting edge to the edge that raises out_valid.
REQ-023 carry_out = final carry; overflow = carry into MSB XOR carry out of MSB; both forced to 0 for ops 000/001.
REQ-024 zero SHALL reflect the final result, including any SLT rewrite, and be valid whenever out_valid is high.
REQ-025 DONE: result and flags hold stable until out_valid&&out_ready, then go to IDLE.
REQ-026 in_ready stays low in DONE, so a new request is never accepted on the same edge as result handoff.
REQ-027 Inputs a, b and operation SHALL be ignored outside the IDLE accept edge; changing them mid-RUN has no effect.

Reset
REQ-028 reset SHALL force state to IDLE and clear result, carry_out, overflow, bit counter and carry to 0.
REQ-029 After reset, in_ready=1, out_valid=0 and zero=1.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered; reset takes priority over all handshakes.

Configuration
REQ-031 Macro ALU_SERIAL_SLT_EN defined: op 111 runs the SUB path; in the DONE transition, result becomes {WIDTH-1 zeros, sum_msb ^ overflow}; carry_out and overflow report the subtraction.
REQ-032 Macro ALU_SERIAL_SLT_EN undefined: op 111 behaves identically to op 110 (SUB); no SLT rewrite logic is present.

Verification (WIDTH=8)
REQ-033 ADD a=0x7F, b=0x01, op 010 -> out_valid 8 cycles after accept; result=0x80, carry_out=0, overflow=1, zero=0.
REQ-034 SUB a=0x05, b=0x05, op 110 -> result=0x00, carry_out=1, overflow=0, zero=1.
REQ-035 AND a=0xF0, b=0x3C, op 000 -> result=0x30; OR with the same operands, op 001 -> result=0xFC; carry_out=0 and overflow=0 in both.
REQ-036 SLT a=0x80, b=0x01, op 111 -> with ALU_SERIAL_SLT_EN: result=0x01; without: result=0x7F, overflow=1.
REQ-037 Back-pressure: hold out_ready=0 for 5 cycles -> result and flags stable, in_ready=0; then out_ready=1 -> IDLE on the next edge.
REQ-038 Reset asserted at RUN bit 3 -> next edge: in_ready=1, out_valid=0, result=0x00; a following ADD 0x03+0x04 returns 0x07.
